// File: rtl/cpu_ad48_trap_unit.sv
// Privilege/trap controller for the cpu_ad48 commit stage: CSRs, prioritised IRQs, trap/IRET.
// Build option: define CPU_AD48_TRAP_VECTORED_EN for per-line interrupt vectors (TVEC + 1 + index).
module cpu_ad48_trap_unit #(
    parameter int unsigned XLEN        = 48,
    parameter int unsigned IRQ_LINES   = 8,
    parameter int unsigned TRAP_VECTOR = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [IRQ_LINES-1:0] irq,
    input  logic                 instr_valid,
    input  logic [XLEN-1:0]      pc_in,
    input  logic                 exc_valid,
    input  logic [3:0]           exc_cause,
    input  logic                 iret,
    input  logic                 csr_req,
    input  logic [1:0]           csr_op,
    input  logic [7:0]           csr_addr,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 trap_take,
    output logic [XLEN-1:0]      trap_target,
    output logic                 iret_take,
    output logic [XLEN-1:0]      iret_target,
    output logic [1:0]           priv_mode,
    output logic [XLEN-1:0]      status
);
    localparam int unsigned ST_W   = 10;
    localparam int unsigned B_MIE  = 6;
    localparam int unsigned B_UPIE = 7;
    localparam int unsigned B_MPIE = 9;

    localparam logic [7:0] A_STATUS  = 8'h00;
    localparam logic [7:0] A_CAUSE   = 8'h01;
    localparam logic [7:0] A_EPC     = 8'h02;
    localparam logic [7:0] A_SCRATCH = 8'h03;
    localparam logic [7:0] A_IE      = 8'h04;
    localparam logic [7:0] A_IP      = 8'h05;
    localparam logic [7:0] A_TVEC    = 8'h06;
    localparam logic [7:0] A_CYCLE   = 8'h10;

    localparam logic [1:0] M_U = 2'd0;
    localparam logic [1:0] M_M = 2'd3;

    localparam logic [1:0] OP_R  = 2'd0;
    localparam logic [1:0] OP_RW = 2'd1;
    localparam logic [1:0] OP_RS = 2'd2;
    localparam logic [1:0] OP_RC = 2'd3;

    logic [ST_W-1:0]      status_q, status_d;
    logic [XLEN-1:0]      cause_q, cause_d, epc_q, epc_d, scratch_q, scratch_d;
    logic [XLEN-1:0]      tvec_q, tvec_d, cycle_q;
    logic [IRQ_LINES-1:0] ie_q, ie_d, ip_q, sync_q, pending;
    logic [1:0]           mode, wmode, wprev;
    logic [3:0]           irq_idx;
    logic                 exc_hit, csr_wr, csr_bad, iret_bad, irq_hit, wr_en;
    logic [XLEN-1:0]      wval, trap_cause;

    assign mode        = status_q[1:0];
    assign pending     = ip_q & ie_q;
    assign exc_hit     = instr_valid & exc_valid;
    assign csr_wr      = instr_valid & csr_req & (csr_op != OP_R);
    assign csr_bad     = instr_valid & csr_req &
                         (((csr_addr != A_CYCLE) & (mode == M_U)) |
                          (csr_wr & ((csr_addr == A_IP) | (csr_addr == A_CYCLE))));
    assign iret_bad    = instr_valid & iret & (mode == M_U);
    assign irq_hit     = instr_valid & (|pending) & ((mode != M_M) | status_q[B_MIE]);
    assign trap_take   = exc_hit | csr_bad | iret_bad | irq_hit;
    assign iret_take   = instr_valid & iret & ~trap_take;
    assign iret_target = epc_q;
    assign wr_en       = csr_wr & ~trap_take & ~iret_take;
    assign priv_mode   = mode;
    assign status      = XLEN'(status_q);

    // CSR read mux, independent of legality
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_STATUS:  csr_rdata = XLEN'(status_q);
            A_CAUSE:   csr_rdata = cause_q;
            A_EPC:     csr_rdata = epc_q;
            A_SCRATCH: csr_rdata = scratch_q;
            A_IE:      csr_rdata = XLEN'(ie_q);
            A_IP:      csr_rdata = XLEN'(ip_q);
            A_TVEC:    csr_rdata = tvec_q;
            A_CYCLE:   csr_rdata = cycle_q;
            default:   csr_rdata = '0;
        endcase
    end

    // Lowest-numbered pending line wins
    always_comb begin
        irq_idx = '0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (pending[i]) irq_idx = 4'(i);
        end
    end

    always_comb begin
        trap_target = tvec_q;
        trap_cause  = XLEN'(exc_cause);
        if (!exc_hit) begin
            if (csr_bad | iret_bad) begin
                trap_cause = XLEN'(2'd2);
            end else begin
                trap_cause = XLEN'({2'b10, irq_idx});
`ifdef CPU_AD48_TRAP_VECTORED_EN
                trap_target = tvec_q + XLEN'(irq_idx) + XLEN'(1'b1);
`endif
            end
        end
    end

    // Write operand and STATUS field sanitising
    always_comb begin
        case (csr_op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = csr_rdata | csr_wdata;
            OP_RC:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
        wmode = wval[1:0];
        if (wmode > mode) wmode = mode;
        if (wmode == 2'd2) wmode = M_U;
        wprev = (wval[3:2] == 2'd2) ? M_U : wval[3:2];
    end

    always_comb begin
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        scratch_d = scratch_q;
        tvec_d    = tvec_q;
        ie_d      = ie_q;
        if (trap_take) begin
            status_d[3:2]    = mode;
            status_d[1:0]    = M_M;
            status_d[B_MPIE] = status_q[B_MIE];
            status_d[B_MIE]  = 1'b0;
            cause_d          = trap_cause;
            epc_d            = pc_in;
        end else if (iret_take) begin
            status_d[1:0]    = status_q[3:2];
            status_d[3:2]    = M_U;
            status_d[B_MIE]  = status_q[B_MPIE];
            status_d[B_MPIE] = 1'b1;
            status_d[B_UPIE] = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                A_STATUS:  status_d  = {wval[ST_W-1:4], wprev, wmode};
                A_CAUSE:   cause_d   = wval;
                A_EPC:     epc_d     = wval;
                A_SCRATCH: scratch_d = wval;
                A_IE:      ie_d      = wval[IRQ_LINES-1:0];
                A_TVEC:    tvec_d    = wval;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q  <= ST_W'(M_M);
            cause_q   <= '0;
            epc_q     <= '0;
            scratch_q <= '0;
            tvec_q    <= XLEN'(TRAP_VECTOR);
            cycle_q   <= '0;
            ie_q      <= '0;
            ip_q      <= '0;
            sync_q    <= '0;
        end else begin
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            scratch_q <= scratch_d;
            tvec_q    <= tvec_d;
            cycle_q   <= cycle_q + XLEN'(1'b1);
            ie_q      <= ie_d;
            sync_q    <= irq;
            ip_q      <= sync_q;
        end
    end
endmodule

// File: tb/tb_cpu_ad48_trap_unit.sv
// Scoreboard bench for cpu_ad48_trap_unit: directed plan sequence, random commits, mid-run reset.
module tb_cpu_ad48_trap_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  irq = '0;
    logic        instr_valid = 1'b0;
    logic [47:0] pc_in = '0;
    logic        exc_valid = 1'b0;
    logic [3:0]  exc_cause = '0;
    logic        iret = 1'b0;
    logic        csr_req = 1'b0;
    logic [1:0]  csr_op = '0;
    logic [7:0]  csr_addr = '0;
    logic [47:0] csr_wdata = '0;
    logic [47:0] csr_rdata, trap_target, iret_target, status;
    logic        trap_take, iret_take;
    logic [1:0]  priv_mode;

    cpu_ad48_trap_unit #(.XLEN(48), .IRQ_LINES(8), .TRAP_VECTOR(64)) dut (
        .clk(clk), .resetn(resetn), .irq(irq), .instr_valid(instr_valid), .pc_in(pc_in),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .iret(iret), .csr_req(csr_req),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .trap_take(trap_take), .trap_target(trap_target), .iret_take(iret_take),
        .iret_target(iret_target), .priv_mode(priv_mode), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        trap;
        logic [47:0] target;
        logic        iret;
        logic [47:0] itgt;
        logic        chk_rd;
        logic [47:0] rd;
        logic [47:0] st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] addrs [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10};
    logic [7:0] cur_irq = '0;

    // Reference architectural state, kept as named fields
    logic [1:0]  m_mode, m_prev;
    logic        m_uie, m_kie, m_mie, m_upie, m_kpie, m_mpie;
    logic [47:0] m_cause, m_epc, m_scratch, m_tvec, m_cycle;
    logic [7:0]  m_ie, m_ip, m_sync;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] m_status();
        logic [47:0] s;
        s = '0;
        s[1:0] = m_mode;
        s[3:2] = m_prev;
        s[4] = m_uie; s[5] = m_kie; s[6] = m_mie;
        s[7] = m_upie; s[8] = m_kpie; s[9] = m_mpie;
        return s;
    endfunction

    function automatic logic [47:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_status();
            8'h01:   return m_cause;
            8'h02:   return m_epc;
            8'h03:   return m_scratch;
            8'h04:   return 48'(m_ie);
            8'h05:   return 48'(m_ip);
            8'h06:   return m_tvec;
            8'h10:   return m_cycle;
            default: return 48'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mode = 2'd3; m_prev = 2'd0;
        {m_uie, m_kie, m_mie, m_upie, m_kpie, m_mpie} = '0;
        m_cause = '0; m_epc = '0; m_scratch = '0; m_tvec = 48'd64; m_cycle = '0;
        m_ie = '0; m_ip = '0; m_sync = '0;
    endtask

    // Drive one commit cycle at the current negedge, predict, then advance to the next negedge
    task automatic step(input logic iv, input logic [47:0] pc, input logic ev, input logic [3:0] ec,
                        input logic ir, input logic cq, input logic [1:0] op, input logic [7:0] ad,
                        input logic [47:0] wd, input logic [7:0] irqv);
        exp_t        e;
        logic [47:0] rd, nv;
        logic        is_w, bad, irq_ok;
        logic [7:0]  pend;
        logic [1:0]  req;
        int          idx;
        instr_valid = iv; pc_in = pc; exc_valid = ev; exc_cause = ec; iret = ir;
        csr_req = cq; csr_op = op; csr_addr = ad; csr_wdata = wd; irq = irqv;

        rd   = m_read(ad);
        is_w = (op != 2'd0);
        bad  = (cq && ((ad != 8'h10 && m_mode == 2'd0) || (is_w && (ad == 8'h05 || ad == 8'h10))))
               || (ir && m_mode == 2'd0);
        pend = m_ip & m_ie;
        idx  = -1;
        for (int i = 7; i >= 0; i--) if (pend[i]) idx = i;
        irq_ok = (idx >= 0) && (m_mode != 2'd3 || m_mie);

        e.trap   = iv && (ev || bad || irq_ok);
        e.iret   = iv && !e.trap && ir;
        e.itgt   = m_epc;
        e.chk_rd = cq;
        e.rd     = rd;
        e.st     = m_status();
        e.target = m_tvec;
`ifdef CPU_AD48_TRAP_VECTORED_EN
        if (!ev && !bad && irq_ok) e.target = m_tvec + 48'(idx + 1);
`endif
        if (iv) sb.push_back(e);

        if (e.trap) begin
            m_cause = ev ? 48'(ec) : (bad ? 48'd2 : 48'(32 + idx));
            m_epc   = pc;
            m_prev  = m_mode; m_mode = 2'd3;
            m_mpie  = m_mie;  m_mie  = 1'b0;
        end else if (e.iret) begin
            m_mode = m_prev; m_prev = 2'd0;
            m_mie  = m_mpie; m_mpie = 1'b1; m_upie = 1'b1;
        end else if (iv && cq && is_w) begin
            case (op)
                2'd1:    nv = wd;
                2'd2:    nv = rd | wd;
                default: nv = rd & ~wd;
            endcase
            case (ad)
                8'h00: begin
                    req = nv[1:0];
                    if (req > m_mode) req = m_mode;
                    if (req == 2'd2) req = 2'd0;
                    m_mode = req;
                    m_prev = (nv[3:2] == 2'd2) ? 2'd0 : nv[3:2];
                    {m_mpie, m_kpie, m_upie, m_mie, m_kie, m_uie} = nv[9:4];
                end
                8'h01:   m_cause = nv;
                8'h02:   m_epc = nv;
                8'h03:   m_scratch = nv;
                8'h04:   m_ie = nv[7:0];
                8'h06:   m_tvec = nv;
                default: ;
            endcase
        end
        m_cycle = m_cycle + 48'd1;
        m_ip    = m_sync;
        m_sync  = irqv;
        @(negedge clk);
    endtask

    task automatic csr(input logic [47:0] pc, input logic [1:0] op, input logic [7:0] ad, input logic [47:0] wd);
        step(1'b1, pc, 1'b0, 4'd0, 1'b0, 1'b1, op, ad, wd, cur_irq);
    endtask

    task automatic nop(input logic [47:0] pc);
        step(1'b1, pc, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'h00, 48'd0, cur_irq);
    endtask

    task automatic idle();
        step(1'b0, 48'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'h00, 48'd0, cur_irq);
    endtask

    task automatic do_reset();
        instr_valid = 1'b0; csr_req = 1'b0; iret = 1'b0; exc_valid = 1'b0;
        cur_irq = 8'hFF; irq = cur_irq;
        resetn = 1'b0;
        m_reset();
        for (int i = 0; i < 8; i++) begin
            csr_addr = addrs[i];
            #1;
            check($sformatf("reset_csr_%02h", addrs[i]), csr_rdata, m_read(addrs[i]));
        end
        check("reset_status", status, 48'h003);
        check("reset_priv", 48'(priv_mode), 48'd3);
        check("reset_trap_take", 48'(trap_take), 48'd0);
        check("reset_iret_take", 48'(iret_take), 48'd0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: pops one expectation per presented commit
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (resetn && instr_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL scoreboard_empty: commit seen with no expectation at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("trap_take", 48'(trap_take), 48'(e.trap));
                    if (e.trap) check("trap_target", trap_target, e.target);
                    check("iret_take", 48'(iret_take), 48'(e.iret));
                    check("iret_target", iret_target, e.itgt);
                    if (e.chk_rd) check("csr_rdata", csr_rdata, e.rd);
                    check("status", status, e.st);
                    check("priv_mode", 48'(priv_mode), 48'(e.st[1:0]));
                end
            end
        end
    end

    initial begin
        logic        iv, ev, ir, cq;
        logic [3:0]  ec;
        logic [1:0]  op, mb;
        logic [7:0]  ad;
        logic [47:0] wd, pc;
        @(negedge clk);
        do_reset();

        // Privilege walk-down, illegal access in U, handler, IRET
        csr(48'd1, 2'd1, 8'h00, 48'h073);
        csr(48'd2, 2'd1, 8'h00, 48'h071);
        csr(48'd3, 2'd1, 8'h00, 48'h074);
        csr(48'd11, 2'd1, 8'h03, 48'h55);
        csr(48'd12, 2'd0, 8'h01, 48'd0);
        csr(48'd13, 2'd0, 8'h02, 48'd0);
        csr(48'd14, 2'd0, 8'h03, 48'd0);
        csr(48'd15, 2'd1, 8'h02, 48'd12);
        step(1'b1, 48'd16, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 8'h00, 48'd0, cur_irq);
        nop(48'd17);
        step(1'b1, 48'd18, 1'b1, 4'd7, 1'b0, 1'b0, 2'd0, 8'h00, 48'd0, cur_irq);

        // Two lines raised together, lowest enabled index wins
        csr(48'd19, 2'd1, 8'h04, 48'h0A);
        csr(48'd19, 2'd1, 8'h00, 48'h043);
        cur_irq = 8'h0A;
        idle();
        idle();
        nop(48'd20);
        csr(48'd21, 2'd0, 8'h01, 48'd0);
        nop(48'd22);
        csr(48'd23, 2'd1, 8'h00, 48'h001);
        nop(48'd24);

        // Exception outranks pending interrupt and a STATUS write
        csr(48'd25, 2'd1, 8'h00, 48'h001);
        step(1'b1, 48'd26, 1'b1, 4'd5, 1'b0, 1'b1, 2'd1, 8'h00, 48'h003, cur_irq);
        csr(48'd26, 2'd0, 8'h01, 48'd0);
        cur_irq = 8'h00;
        idle();
        idle();

        // Mode clamp in S, CYCLE access from U
        csr(48'd27, 2'd1, 8'h00, 48'h001);
        csr(48'd28, 2'd1, 8'h00, 48'h003);
        csr(48'd29, 2'd0, 8'h00, 48'd0);
        csr(48'd30, 2'd1, 8'h00, 48'h000);
        csr(48'd31, 2'd0, 8'h10, 48'd0);
        csr(48'd32, 2'd1, 8'h10, 48'd5);
        csr(48'd33, 2'd0, 8'h01, 48'd0);

        // Random commits with a reset in the middle
        for (int k = 0; k < 700; k++) begin
            if (k == 350) do_reset();
            if ($urandom_range(0, 7) == 0) cur_irq = 8'($urandom);
            iv = ($urandom_range(0, 3) != 0);
            ev = ($urandom_range(0, 9) == 0);
            ec = 4'($urandom);
            ir = ($urandom_range(0, 7) == 0);
            cq = 1'($urandom);
            ad = addrs[$urandom_range(0, 7)];
            op = 2'($urandom);
            wd = {16'($urandom), 32'($urandom)};
            if (ad == 8'h00) begin
                op = (op == 2'd0) ? 2'd0 : 2'd1;
                mb = 2'($urandom_range(0, 2));
                if (mb == 2'd2) mb = 2'd3;
                wd = (48'($urandom) & 48'h3FC) | 48'(mb);
            end
            pc = {16'($urandom), 32'($urandom)};
            step(iv, pc, ev, ec, ir, cq, op, ad, wd, cur_irq);
        end

        instr_valid = 1'b0;
        @(negedge clk);
        #3;
        check("scoreboard_drained", 48'(sb.size()), 48'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_ad48_trap_unit.md
# cpu_ad48_trap_unit

Parametrised privilege/trap controller for the cpu_ad48 core. It replaces the fixed single-vector trap logic with N prioritised interrupt lines, per-line enable/pending CSRs and a programmable trap vector. It owns the privilege-mode stack (STATUS), CAUSE, EPC, SCRATCH, IE, IP, TVEC and CYCLE, and checks CSR access privilege. It sits beside the commit stage: the core presents the committing instruction and the unit decides trap, IRET or normal retire.

## Interface
- XLEN, 48: CSR and PC width.
- IRQ_LINES, 8: interrupt line count, 1..16.
- TRAP_VECTOR, 64: reset value of TVEC (word address).
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- irq  in  IRQ_LINES  level-sensitive interrupt lines, asynchronous to clk.
- instr_valid  in  1  an instruction is at commit this cycle.
- pc_in  in  XLEN  PC of the committing instruction.
- exc_valid  in  1  committing instruction raised a synchronous exception.
- exc_cause  in  4  exception code.
- iret  in  1  committing instruction is IRET.
- csr_req  in  1  committing instruction is a CSR access.
- csr_op  in  2  0=R, 1=RW, 2=RS (set bits), 3=RC (clear bits).
- csr_addr  in  8  CSR address.
- csr_wdata  in  XLEN  write operand.
- csr_rdata  out  XLEN  read data, combinational.
- trap_take  out  1  redirect to trap_target; the committing instruction is squashed.
- trap_target  out  XLEN  handler address.
- iret_take  out  1  redirect to EPC.
- iret_target  out  XLEN  current EPC.
- priv_mode  out  2  current mode: 0=U, 1=S, 3=M.
- status  out  XLEN  STATUS register.

## Operation
- CSR map:
  - 0x00 STATUS
  - 0x01 CAUSE
  - 0x02 EPC
  - 0x03 SCRATCH
  - 0x04 IE
  - 0x05 IP (RO)
  - 0x06 TVEC
  - 0x10 CYCLE (RO)
- STATUS layout:
  - [1:0] mode
  - [3:2] prev mode
  - 4 UIE, 5 KIE, 6 MIE
  - 7 UPIE, 8 KPIE, 9 MPIE
  - other bits read 0.
- Access rules:
  - CYCLE read is legal in any mode.
  - All other CSRs require mode ≥ S.
  - Any write to IP or CYCLE is illegal; R op never writes.
  - A STATUS mode-field write above the current mode is clamped to the current mode.
  - Prev-mode value 2 is written as 0.
- Illegal access or IRET in U mode: the unit itself takes a trap with CAUSE=2 and EPC=pc_in.
- Trap entry:
  - STATUS: prev←mode, mode←M, MPIE←MIE, MIE←0; UIE/KIE unchanged.
  - CAUSE←code; EPC←pc_in; CYCLE keeps counting.
- IRET:
  - STATUS: mode←prev, prev←U, MIE←MPIE, MPIE←1, UPIE←1.
  - iret_take=1, iret_target=EPC.
- Interrupts:
  - irq passes a 2-flop synchroniser into IP, which tracks the level (not sticky).
  - Pending = IP & IE[IRQ_LINES-1:0].
  - Enabled when mode<M, or when mode==M and MIE=1.
  - Taken only when instr_valid=1; the lowest index wins.
  - CAUSE = {1'b1 at bit 5, index in [3:0]}; EPC = pc_in (instruction not retired).
- Priority within a cycle (highest first):
  1. exc_valid
  2. illegal CSR / U-mode IRET
  3. interrupt
  4. iret
  5. CSR write
- A trap or IRET discards a same-cycle CSR write; csr_rdata still reflects the pre-edge value.
- CYCLE increments every clock and wraps 2^48−1→0.

## Timing
- trap_take, trap_target, iret_take and csr_rdata are combinational from inputs and current state. All CSR updates occur on the same rising edge.
- irq to IP: 2 cycles. IP to trap_take: same cycle, given instr_valid.
- trap_take and iret_take are never high together.
- Reset values (reset asynchronous on assertion; deassertion seen at next edge):
  - STATUS=0x003 (mode M, all enables 0)
  - CAUSE=0, EPC=0, SCRATCH=0, IE=0, IP=0
  - TVEC=TRAP_VECTOR, CYCLE=0, synchroniser flops 0
  - trap_take=0, iret_take=0
- Reset mid-handler: all state returns to reset values; no trap is pending after release.

## Configuration
- CPU_AD48_TRAP_VECTORED_EN defined:
  - Interrupt target = TVEC + 1 + index.
  - Exceptions target TVEC.
- Undefined: all traps target TVEC. The resulting CAUSE values are identical in both builds.

## Test plan
- Write STATUS=0x073 (M), then 0x071, then 0x074 (U, prev S). Then an RW to SCRATCH at pc 11 → trap_take=1, target 64, CAUSE=2, EPC=11, STATUS mode=3, prev=0, MIE=0, MPIE=1, SCRATCH=0.
- From that handler, EPC←12 then IRET → iret_target=12, priv_mode=0, MIE=1, MPIE=1, UPIE=1, prev=0.
- IE=0x0A, MIE=1 in M; raise irq[3] and irq[1] together → 2 cycles later, with instr_valid at pc 20: CAUSE=0x21, EPC=20. Target 64, or 66 with CPU_AD48_TRAP_VECTORED_EN.
- irq[1] pending with MIE=0 in M → no trap. Drop to S → trap on the first instr_valid.
- exc_valid (cause 5) coincident with a pending interrupt and a STATUS write → CAUSE=5, STATUS write discarded.
- In S, write STATUS mode=3 → reads back mode=1. CYCLE read in U is legal; CYCLE write → CAUSE=2.
